// File: rtl/m_stage_dmem.sv
// M-stage data memory: byte/half/word stores into a word-addressed RAM, load extraction
// and sign/zero extension, and the M/W pipeline register.
module m_stage_dmem #(
    parameter int unsigned ADDR_W = 12,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_m,
    input  logic [31:0] ao_m,
    input  logic [31:0] v2_m,
    input  logic [4:0]  a3_m,
    input  logic [31:0] pc8_m,
    input  logic        W_M,
    output logic [31:0] instr_w,
    output logic [31:0] ao_w,
    output logic [31:0] dr_w,
    output logic [4:0]  a3_w,
    output logic [31:0] pc8_w,
    output logic        W_W,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic        addr_err
);
    localparam int unsigned Words = 2 ** ADDR_W;

    typedef enum logic [1:0] {SzNone, SzByte, SzHalf, SzWord} size_e;

    logic [5:0]        opcode;
    logic              is_load;
    logic              is_store;
    logic              ld_signed;
    size_e             size;
    logic [31:0]       off;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    logic              aligned;
    logic              misaligned;

    assign opcode = instr_m[31:26];
    assign off    = ao_m - BASE;
    assign idx    = off[ADDR_W+1:2];
    assign lane   = off[1:0];

    logic unused_off;
    assign unused_off = ^off[31:ADDR_W+2];

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        ld_signed = 1'b0;
        size      = SzNone;
        case (opcode)
            6'b100011: begin is_load = 1'b1; size = SzWord; end
            6'b100000: begin is_load = 1'b1; size = SzByte; ld_signed = 1'b1; end
            6'b100100: begin is_load = 1'b1; size = SzByte; end
            6'b100001: begin is_load = 1'b1; size = SzHalf; ld_signed = 1'b1; end
            6'b100101: begin is_load = 1'b1; size = SzHalf; end
            6'b101011: begin is_store = 1'b1; size = SzWord; end
            6'b101001: begin is_store = 1'b1; size = SzHalf; end
            6'b101000: begin is_store = 1'b1; size = SzByte; end
            default: ;
        endcase
    end

    always_comb begin
        aligned = 1'b1;
        unique case (size)
            SzWord:  aligned = (lane == 2'b00);
            SzHalf:  aligned = ~lane[0];
            default: aligned = 1'b1;
        endcase
    end

    assign misaligned = (is_load | is_store) & ~aligned;

    // Per-word valid bits make reset clear the whole RAM in one cycle: an invalid
    // word reads as zero and its first write fills the unwritten bytes with zero.
    logic [31:0]      ram [Words];
    logic [Words-1:0] valid_q;
    logic [31:0]      cur_word;
    logic [31:0]      merged;

    assign cur_word = valid_q[idx] ? ram[idx] : '0;

    always_comb begin
        mem_be    = '0;
        mem_wdata = '0;
        if (is_store) begin
            unique case (size)
                SzWord: begin
                    mem_be    = 4'b1111;
                    mem_wdata = v2_m;
                end
                SzHalf: begin
                    mem_be    = lane[1] ? 4'b1100 : 4'b0011;
                    mem_wdata = {2{v2_m[15:0]}};
                end
                SzByte: begin
                    mem_be    = 4'b0001 << lane;
                    mem_wdata = {4{v2_m[7:0]}};
                end
                default: ;
            endcase
        end
    end

    assign mem_we = is_store & aligned & ~reset;

    always_comb begin
        merged = cur_word;
        for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) merged[8*b +: 8] = mem_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (mem_we) begin
            valid_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) ram[idx] <= merged;
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign ld_byte = cur_word[{lane, 3'b000} +: 8];
    assign ld_half = lane[1] ? cur_word[31:16] : cur_word[15:0];

    always_comb begin
        ld_data = '0;
        if (is_load && aligned) begin
            unique case (size)
                SzWord:  ld_data = cur_word;
                SzHalf:  ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
                SzByte:  ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
                default: ld_data = '0;
            endcase
        end
    end

    logic [31:0] instr_q, ao_q, dr_q, pc8_q;
    logic [4:0]  a3_q;
    logic        w_q, err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
            ao_q    <= '0;
            dr_q    <= '0;
            a3_q    <= '0;
            pc8_q   <= '0;
            w_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            instr_q <= instr_m;
            ao_q    <= ao_m;
            dr_q    <= ld_data;
            a3_q    <= a3_m;
            pc8_q   <= pc8_m;
            w_q     <= W_M & ~(is_load & misaligned);
            err_q   <= misaligned;
        end
    end

    assign instr_w  = instr_q;
    assign ao_w     = ao_q;
    assign dr_w     = dr_q;
    assign a3_w     = a3_q;
    assign pc8_w    = pc8_q;
    assign W_W      = w_q;
    assign addr_err = err_q;

endmodule

// File: tb/tb_m_stage_dmem.sv
// Bench for m_stage_dmem: byte-array reference model, directed plan plus random traffic.
module tb_m_stage_dmem;
    localparam int unsigned AddrW = 12;
    localparam int unsigned Bytes = 4 << AddrW;
    localparam logic [31:0] Base  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_m = '0, ao_m = '0, v2_m = '0, pc8_m = '0;
    logic [4:0]  a3_m = '0;
    logic        W_M = 1'b0;
    logic [31:0] instr_w, ao_w, dr_w, pc8_w, mem_wdata;
    logic [4:0]  a3_w;
    logic        W_W, mem_we, addr_err;
    logic [3:0]  mem_be;

    m_stage_dmem #(.ADDR_W(AddrW), .BASE(Base)) dut (
        .clk(clk), .reset(reset), .instr_m(instr_m), .ao_m(ao_m), .v2_m(v2_m),
        .a3_m(a3_m), .pc8_m(pc8_m), .W_M(W_M), .instr_w(instr_w), .ao_w(ao_w),
        .dr_w(dr_w), .a3_w(a3_w), .pc8_w(pc8_w), .W_W(W_W), .mem_we(mem_we),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] mb [Bytes];
    logic       s_we;
    logic [3:0] s_be;

    localparam logic [5:0] OpLw = 6'b100011, OpLb = 6'b100000, OpLbu = 6'b100100;
    localparam logic [5:0] OpLh = 6'b100001, OpLhu = 6'b100101;
    localparam logic [5:0] OpSw = 6'b101011, OpSh = 6'b101001, OpSb = 6'b101000;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // kind: 0 none, 1 load, 2 store; sz in bytes
    task automatic decode(input logic [5:0] op, output int kind, output int sz, output bit sgn);
        kind = 0; sz = 1; sgn = 0;
        case (op)
            OpLw:  begin kind = 1; sz = 4; end
            OpLb:  begin kind = 1; sz = 1; sgn = 1; end
            OpLbu: begin kind = 1; sz = 1; end
            OpLh:  begin kind = 1; sz = 2; sgn = 1; end
            OpLhu: begin kind = 1; sz = 2; end
            OpSw:  begin kind = 2; sz = 4; end
            OpSh:  begin kind = 2; sz = 2; end
            OpSb:  begin kind = 2; sz = 1; end
            default: ;
        endcase
    endtask

    task automatic step(input logic [5:0] op, input logic [31:0] ao, input logic [31:0] v2,
                        input logic wm, input logic rst);
        int kind, sz, lane;
        bit sgn, mis, exp_we;
        logic [31:0] instr, off, exp_wd, mask, ld, pc8;
        logic [3:0]  exp_be;
        logic [4:0]  a3;
        decode(op, kind, sz, sgn);
        instr = (op == 6'd0) ? 32'd0 : {op, 26'($urandom)};
        a3    = 5'($urandom);
        pc8   = $urandom;
        @(negedge clk);
        instr_m = instr; ao_m = ao; v2_m = v2; a3_m = a3; pc8_m = pc8; W_M = wm; reset = rst;
        #1;
        off    = ao - Base;
        mis    = (kind != 0) && ((off % sz) != 0);
        exp_we = (kind == 2) && !mis && !rst;
        exp_be = '0; exp_wd = '0; mask = '0;
        if (exp_we) begin
            for (int k = 0; k < sz; k++) begin
                lane = int'((off + k) % 4);
                exp_be[lane] = 1'b1;
                exp_wd[8*lane +: 8] = v2[8*k +: 8];
                mask[8*lane +: 8] = 8'hFF;
            end
        end
        chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        if (exp_we) begin
            chk("mem_be", {28'd0, mem_be}, {28'd0, exp_be});
            chk("mem_wdata", mem_wdata & mask, exp_wd);
        end
        s_we = mem_we;
        s_be = mem_be;
        ld = '0;
        if (kind == 1 && !mis) begin
            for (int k = 0; k < sz; k++) ld = ld + ({24'd0, mb[(off + k) % Bytes]} << (8 * k));
            if (sgn && sz == 1 && ld >= 32'd128)   ld = ld - 32'd256;
            if (sgn && sz == 2 && ld >= 32'h8000)  ld = ld - 32'h10000;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < Bytes; i++) mb[i] = 8'h00;
        end else if (exp_we) begin
            for (int k = 0; k < sz; k++) mb[(off + k) % Bytes] = v2[8*k +: 8];
        end
        chk("instr_w", instr_w, rst ? 32'd0 : instr);
        chk("ao_w", ao_w, rst ? 32'd0 : ao);
        chk("a3_w", {27'd0, a3_w}, rst ? 32'd0 : {27'd0, a3});
        chk("pc8_w", pc8_w, rst ? 32'd0 : pc8);
        chk("dr_w", dr_w, rst ? 32'd0 : ld);
        chk("W_W", {31'd0, W_W}, (rst || (kind == 1 && mis)) ? 32'd0 : {31'd0, wm});
        chk("addr_err", {31'd0, addr_err}, (rst || !mis) ? 32'd0 : 32'd1);
    endtask

    initial begin
        logic [5:0] ops [11];
        logic [31:0] a;
        ops = '{OpLw, OpLb, OpLbu, OpLh, OpLhu, OpSw, OpSh, OpSb, 6'd0, 6'b001000, 6'b111111};

        step(6'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        step(6'd0, 32'd0, 32'd0, 1'b0, 1'b1);

        step(OpSw, 32'h10, 32'h1234_5678, 1'b0, 1'b0);
        chk("lit_sw_we", {31'd0, s_we}, 32'd1);
        chk("lit_sw_be", {28'd0, s_be}, 32'hF);
        step(OpLw, 32'h10, 32'h0, 1'b1, 1'b0);
        chk("lit_lw", dr_w, 32'h1234_5678);
        chk("lit_lw_ww", {31'd0, W_W}, 32'd1);

        step(OpSb, 32'h13, 32'h0000_00AB, 1'b0, 1'b0);
        chk("lit_sb_be", {28'd0, s_be}, 32'h8);
        step(OpLw, 32'h10, 32'h0, 1'b1, 1'b0);
        chk("lit_lw_after_sb", dr_w, 32'hAB34_5678);
        step(OpLb, 32'h13, 32'h0, 1'b1, 1'b0);
        chk("lit_lb", dr_w, 32'hFFFF_FFAB);
        step(OpLbu, 32'h13, 32'h0, 1'b1, 1'b0);
        chk("lit_lbu", dr_w, 32'h0000_00AB);

        step(6'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        step(OpSh, 32'h12, 32'h0000_8001, 1'b0, 1'b0);
        chk("lit_sh_be", {28'd0, s_be}, 32'hC);
        step(OpLh, 32'h12, 32'h0, 1'b1, 1'b0);
        chk("lit_lh", dr_w, 32'hFFFF_8001);
        step(OpLhu, 32'h12, 32'h0, 1'b1, 1'b0);
        chk("lit_lhu", dr_w, 32'h0000_8001);
        step(OpLh, 32'h10, 32'h0, 1'b1, 1'b0);
        chk("lit_lh_low", dr_w, 32'h0);

        step(OpSw, 32'h21, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("lit_missw_we", {31'd0, s_we}, 32'd0);
        chk("lit_missw_err", {31'd0, addr_err}, 32'd1);
        step(OpLw, 32'h20, 32'h0, 1'b1, 1'b0);
        chk("lit_missw_ram", dr_w, 32'h0);
        chk("lit_err_clears", {31'd0, addr_err}, 32'd0);
        step(OpLh, 32'h23, 32'h0, 1'b1, 1'b0);
        chk("lit_mislh_dr", dr_w, 32'h0);
        chk("lit_mislh_ww", {31'd0, W_W}, 32'd0);
        chk("lit_mislh_err", {31'd0, addr_err}, 32'd1);

        step(OpSw, 32'h4000, 32'hCAFE_BABE, 1'b0, 1'b0);
        step(OpLw, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("lit_alias", dr_w, 32'hCAFE_BABE);

        step(OpSw, 32'h10, 32'h5555_5555, 1'b0, 1'b1);
        chk("lit_rst_we", {31'd0, s_we}, 32'd0);
        chk("lit_rst_dr", dr_w, 32'h0);
        step(OpLw, 32'h10, 32'h0, 1'b1, 1'b0);
        chk("lit_rst_lost", dr_w, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            a = $urandom_range(0, 127);
            if ($urandom_range(0, 7) == 0) a = a | ($urandom << 14);
            step(ops[$urandom_range(0, 10)], a, $urandom, 1'($urandom),
                 $urandom_range(0, 199) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
